// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 device transmitter and the
// ps2_keyboard receiver.
//   - frame layout constants (11-bit device-to-host frame)
//   - serialiser state enum
//   - odd-parity and frame-building helpers
//   - common scan codes
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic       PS2_START      = 1'b0;
  localparam logic       PS2_STOP       = 1'b1;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTEND     = 8'hE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ps2_state_e;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame bit 0 is sent first: start, data LSB..MSB, parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {PS2_STOP, odd_parity(b), b, PS2_START};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: small synchronous FIFO in front of the PS/2 serialiser.
// Ports:
//   clk, resetn  system clock, async active-low reset (empties the FIFO)
//   push, din    write request and data; ignored while full
//   pop          read request; ignored while empty
//   dout         head entry (valid while !empty)
//   full, empty  status flags
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: keyboard end of a PS/2 link. Accepts bytes on a valid/ready
// handshake and sends each one as an 11-bit device-to-host frame on
// ps2_clk/ps2_data, followed by an idle gap.
// Ports:
//   clk       system clock
//   resetn    async active-low reset; lines go idle at once, frame dropped
//   in_data   byte to send, sampled on handshake
//   in_valid  in_data valid
//   in_ready  byte can be accepted (transfer when in_valid && in_ready)
//   ps2_clk   PS/2 clock, registered
//   ps2_data  PS/2 data, registered, changes only while ps2_clk is high
//   busy      frame or gap in progress, or bytes queued
// Optional build macro: PS2_TX_FIFO_EN puts a FIFO_DEPTH-entry FIFO in front
// of the serialiser (in_ready = !full). Without it, in_ready is high only
// in IDLE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lines idle, waiting for a byte
// SHIFT | sending frame bit bit_idx; phase walks one ps2_clk period
// GAP   | lines idle for the inter-frame gap
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_BITS    = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int PHASE_W   = (2*HALF_PERIOD > 1) ? $clog2(2*HALF_PERIOD) : 1;
  localparam int GAP_CYC   = GAP_BITS * 2 * HALF_PERIOD;
  // The single IDLE cycle that follows GAP is the last idle-line cycle of the
  // gap, so a continuously fed link repeats every (22+2*GAP_BITS)*HALF_PERIOD.
  // The down-counter runs LOAD..0, i.e. LOAD+1 cycles in GAP.
  localparam int GAP_LOAD  = (GAP_CYC >= 2) ? GAP_CYC - 2 : 0;
  localparam int GAP_W     = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;
  localparam bit HAS_GAP   = (GAP_BITS > 0);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2*HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(HALF_PERIOD);
  localparam logic [3:0]         LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state,   state_d;
  logic [PHASE_W-1:0]        phase,   phase_d;
  logic [3:0]                bit_idx, bit_idx_d;
  logic [PS2_FRAME_BITS-1:0] shreg,   shreg_d;
  logic [GAP_W-1:0]          gap_cnt, gap_cnt_d;
  logic                      ps2_clk_d;
  logic                      ps2_data_d;
  logic                      rdy_en;
  logic                      start;
  logic [7:0]                load_byte;

`ifdef PS2_TX_FIFO_EN
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  assign in_ready  = rdy_en && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign start     = fifo_pop;
  assign load_byte = fifo_dout;
  assign busy      = (state != IDLE) || !fifo_empty;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (in_data),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
`else
  assign in_ready  = rdy_en && (state == IDLE);
  assign start     = in_valid && in_ready;
  assign load_byte = in_data;
  assign busy      = (state != IDLE);
`endif

  // Holds in_ready low during reset even though the FSM already sits in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      phase    <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      gap_cnt  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      gap_cnt  <= gap_cnt_d;
      ps2_clk  <= ps2_clk_d;
      ps2_data <= ps2_data_d;
    end
  end

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    gap_cnt_d = gap_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          phase_d   = '0;
          bit_idx_d = '0;
          shreg_d   = build_frame(load_byte);
        end
      end
      SHIFT: begin
        if (phase == PHASE_LAST) begin
          if (bit_idx == LAST_BIT) begin
            if (HAS_GAP) begin
              state_d   = GAP;
              gap_cnt_d = GAP_W'(GAP_LOAD);
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx + 4'd1;
            phase_d   = '0;
            shreg_d   = {1'b1, shreg[PS2_FRAME_BITS-1:1]};
          end
        end else begin
          phase_d = phase + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d   = IDLE;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Lines are registered from next-state values so the start bit shows up
    // on the cycle right after the loading edge.
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    if (state_d == SHIFT) begin
      ps2_clk_d  = (phase_d < PHASE_HIGH);
      ps2_data_d = shreg_d[0];
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
module tb_ps2_device_tx;
  import ps2_pkg::*;

  localparam int HP        = 4;
  localparam int GAPB      = 2;
  localparam int FRAME_CYC = 22 * HP;                 // 88
  localparam int PERIOD    = (22 + 2 * GAPB) * HP;    // 104
`ifdef PS2_TX_FIFO_EN
  localparam int LAT       = 1;
  localparam int RDY_AFTER = 1;
`else
  localparam int LAT       = 0;
  localparam int RDY_AFTER = 0;
`endif
  localparam logic [10:0] FRAME_1C = 11'b10000111000;  // 0,0,0,1,1,1,0,0,0,0,1
  localparam logic [10:0] FRAME_F0 = 11'b11111100000;  // 0,0,0,0,0,1,1,1,1,1,1

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          frames_seen = 0;
  logic [10:0] last_frame = '0;
  logic [7:0]  exp_q [$];

  ps2_device_tx #(
    .HALF_PERIOD (HP),
    .GAP_BITS    (GAPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  // Presents a byte until accepted; returns cyc as seen just after the handshake edge.
  task automatic send(input logic [7:0] b, input bit expect_it, output int hs);
    int g;
    g = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 1500) begin
      step(1);
      g++;
    end
    check("send_ready_timeout", in_ready, 1);
    if (expect_it) exp_q.push_back(b);
    step(1);
    hs = cyc;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while ((busy || exp_q.size() != 0) && g < budget) begin
      step(1);
      g++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int hs, hs1, g, first_rdy, f0;
    logic [7:0] fifo_bytes [9];

    resetn   = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;

    fork
      begin : monitor
        logic [10:0] sh;
        int          nb;
        logic [7:0]  eb;
        nb = 0;
        sh = '0;
        forever begin
          @(negedge ps2_clk or negedge resetn);
          #1;
          if (!resetn) begin
            nb = 0;
          end else begin
            sh = {ps2_data, sh[10:1]};
            nb++;
            if (nb == 11) begin
              nb = 0;
              last_frame = sh;
              frames_seen++;
              if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: got frame %0h expected none", sh);
              end else begin
                eb = exp_q.pop_front();
                check("rx_byte", sh[8:1], eb);
                check("rx_frame", sh, {1'b1, ~^eb, eb, 1'b0});
              end
            end
          end
        end
      end
      begin : stability
        forever begin
          @(ps2_data);
          #1;
          if (resetn === 1'b1) check("data_change_clk_high", ps2_clk, 1);
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values, applied asynchronously between clock edges.
    #2 resetn = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    step(3);
    check("rst_in_ready_clocked", in_ready, 0);
    resetn = 1'b1;
    step(1);
    check("ready_after_release", in_ready, 1);
    check("busy_after_release", busy, 0);

    // 0x1C: latency, first falling edge, frame end, busy fall.
    send(8'h1C, 1'b1, hs);
    check("busy_after_hs", busy, 1);
    check("ready_after_hs", in_ready, RDY_AFTER);
    step(LAT);
    check("start_bit_data", ps2_data, 0);
    check("start_bit_clk", ps2_clk, 1);
    g = 0;
    while (ps2_clk && g < 50) begin
      step(1);
      g++;
    end
    check("first_fall_delay", cyc - hs, HP + LAT);
    wait_cyc(hs + LAT + FRAME_CYC - 1);
    check("last_bit_clk_low", ps2_clk, 0);
    check("stop_bit_data", ps2_data, 1);
    step(1);
    check("frame_end_clk", ps2_clk, 1);
    check("frame_end_busy", busy, 1);
    g = 0;
    while (busy && g < 200) begin
      step(1);
      g++;
    end
    check("busy_fall_delay", cyc - hs, LAT + FRAME_CYC + 2 * GAPB * HP - 1);
    check("frame_1c_bits", last_frame, FRAME_1C);

    // 0xF0 (break code).
    send(PS2_BREAK, 1'b1, hs);
    wait_idle(300);
    check("frame_f0_bits", last_frame, FRAME_F0);

`ifdef PS2_TX_FIFO_EN
    // Nine back-to-back pushes: the first is popped right away, so the ninth
    // fills the FIFO.
    fifo_bytes = '{8'h1C, 8'hF0, 8'h32, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80};
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = fifo_bytes[i];
      check($sformatf("fifo_ready_%0d", i), in_ready, 1);
      exp_q.push_back(fifo_bytes[i]);
      step(1);
      if (i == 0) check("fifo_no_bypass", ps2_data, 1);
      if (i == 1) check("fifo_start_bit", ps2_data, 0);
    end
    check("fifo_full_ready", in_ready, 0);
    in_data = 8'hEE;
    step(5);
    check("fifo_full_hold", in_ready, 0);
    in_valid = 1'b0;
    wait_idle(9 * PERIOD + 100);
    check("fifo_all_sent", exp_q.size(), 0);
`else
    // Continuous valid: second frame follows exactly one frame+gap later.
    in_data  = PS2_BREAK;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      step(1);
      g++;
    end
    exp_q.push_back(PS2_BREAK);
    exp_q.push_back(8'h1C);
    step(1);
    hs = cyc;
    in_data = 8'h1C;
    check("ready_low_in_shift", in_ready, 0);
    g = 0;
    while (!in_ready && g < 300) begin
      step(1);
      g++;
    end
    first_rdy = cyc;
    check("ready_return_delay", first_rdy - hs, PERIOD - 1);
    step(1);
    hs1 = cyc;
    in_valid = 1'b0;
    check("frame_spacing", hs1 - hs, PERIOD);
    check("second_start_bit", ps2_data, 0);
    wait_idle(300);
`endif

    // Reset during bit 5 (ps2_clk low phase).
    send(8'h1C, 1'b0, hs);
    wait_cyc(hs + LAT + 11 * HP + 1);
    check("pre_reset_clk_low", ps2_clk, 0);
    f0 = frames_seen;
    #3 resetn = 1'b0;
    #1;
    check("midreset_ps2_clk", ps2_clk, 1);
    check("midreset_ps2_data", ps2_data, 1);
    check("midreset_busy", busy, 0);
    check("midreset_ready", in_ready, 0);
    step(2);
    resetn = 1'b1;
    step(1);
    check("post_reset_ready", in_ready, 1);
    send(8'h1C, 1'b1, hs);
    wait_idle(300);
    check("post_reset_frame", last_frame, FRAME_1C);
    check("post_reset_frame_count", frames_seen - f0, 1);

    // Receiver loopback sequence.
    f0 = frames_seen;
    send(8'h1C, 1'b1, hs);
    send(PS2_BREAK, 1'b1, hs);
    send(8'h1C, 1'b1, hs);
    wait_idle(600);
    check("loopback_frames", frames_seen - f0, 3);
    check("loopback_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Models the keyboard end of the PS/2 link. Sends scan-code bytes as device-to-host frames on ps2_clk/ps2_data.
- Is the counterpart of the existing ps2_keyboard receiver. Used in simulation benches and on the board top to drive that receiver without a physical keyboard.
- Bytes are accepted through a valid/ready handshake, serialised LSB-first with odd parity, then followed by a fixed idle gap.

Parameters:
- HALF_PERIOD, 4, clk cycles per ps2_clk half-period; legal range ≥1.
- GAP_BITS, 2, idle bit-periods (ps2_clk=1, ps2_data=1) inserted after each stop bit.
- FIFO_DEPTH, 8, input FIFO entries; power of 2, ≥2. Used only when PS2_TX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_data  in  8  byte to transmit; sampled only on handshake.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- ps2_clk  out  1  PS/2 clock, registered.
- ps2_data  out  1  PS/2 data, registered.
- busy  out  1  high in SHIFT or GAP, or while the FIFO is non-empty.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE; ps2_clk=1, ps2_data=1, busy=0.
  - in_ready=0 while resetn=0, and 1 from the first edge after release.
  - Any frame in flight is discarded. FIFO is emptied.
- Frame contents, 11 bits, index 0..10:
  - bit 0: start = 0
  - bits 1..8: in_data[0]..in_data[7]
  - bit 9: odd parity = ~^in_data
  - bit 10: stop = 1
- States:
  - IDLE: ps2_clk=1, ps2_data=1. On handshake, latch the byte into the shift register and go to SHIFT with bit_idx=0, phase=0.
  - SHIFT:
    - phase counts 0..2*HALF_PERIOD-1.
    - ps2_clk=1 for phase<HALF_PERIOD, else 0.
    - ps2_data=frame[bit_idx], held for the whole bit period, so data only changes while ps2_clk is high.
    - At phase=2*HALF_PERIOD-1: if bit_idx=10, go to GAP; otherwise bit_idx+1 and phase=0.
  - GAP: ps2_clk=1, ps2_data=1 for GAP_BITS*2*HALF_PERIOD cycles, then go to IDLE.
- Timing:
  - Start bit appears on ps2_data the cycle after the handshake edge.
  - First ps2_clk falling edge comes HALF_PERIOD cycles later.
  - Frame length is 22*HALF_PERIOD cycles; frame plus gap is (22+2*GAP_BITS)*HALF_PERIOD.
  - Receiver samples ps2_data on the ps2_clk falling edge.
- Handshake without FIFO:
  - in_ready=1 only in IDLE; a handshake moves the block out of IDLE.
  - in_valid in SHIFT or GAP is ignored. in_data need not be stable outside the handshake cycle.
- busy rises on the cycle after the handshake and falls on entry to IDLE.
- Counter widths: phase is clog2(2*HALF_PERIOD) bits and wraps only by explicit reset to 0, never by overflow. bit_idx is 4 bits.

Optional Feature:
- PS2_TX_FIFO_EN defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the serialiser; in_ready = !full, independent of state.
  - The serialiser pops when in IDLE and the FIFO is non-empty. There is no bypass: a push into an empty FIFO starts the frame 2 cycles after the handshake edge.
  - Simultaneous push and pop: both succeed, count unchanged.
  - Full: in_ready=0, no overwrite.
  - Back-to-back bytes are separated by exactly the GAP plus 1 IDLE cycle.
- PS2_TX_FIFO_EN undefined: no FIFO logic and the handshake behaves as described in Behaviour.

Decomposition:
- Shared package ps2_pkg:
  - frame constants: PS2_FRAME_BITS=11, PS2_START=0, PS2_STOP=1
  - state enum {IDLE, SHIFT, GAP}
  - odd-parity function
  - common scan codes, e.g. PS2_BREAK=8'hF0, shared with ps2_keyboard
- One sub-module, ps2_tx_fifo: synchronous FIFO, resetn async, push/pop/full/empty/dout. Instantiated only under PS2_TX_FIFO_EN.

Test Plan:
- Send 0x1C with HALF_PERIOD=4 -> bits on successive ps2_clk falling edges are 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame lasts 88 cycles; busy then drops after the 16-cycle gap.
- Send 0xF0 -> data bits 0,0,0,0,1,1,1,1, parity 1; ps2_data never toggles while ps2_clk=0.
- No FIFO: assert in_valid continuously with 0xF0 then 0x1C -> in_ready=0 throughout SHIFT/GAP; second frame starts exactly 104 cycles after the first.
- PS2_TX_FIFO_EN: push 9 bytes back-to-back with FIFO_DEPTH=8 -> in_ready drops at the correct cycle once full (the serialiser has already popped the first byte); every accepted byte is transmitted in order and none is lost.
- Assert resetn=0 during bit 5 -> ps2_clk=1 and ps2_data=1 immediately without waiting for clk; after release, a fresh 0x1C frame is correct.
- Loopback into ps2_keyboard: send 0x1C, 0xF0, 0x1C -> receiver reports the same three bytes with no parity error.
